branch_resolve_ctrl: RTL and testbench

- Execute-stage sequencer that resolves one branch or jump at a time using the registered shift-left-by-2 unit (1-cycle latency).
- Accepts a request from ID/EX over a valid/ready handshake, then steps the request through the shift stage, target add and compare.
- Delivers a taken/target result to the fetch-redirect logic over a second valid/ready handshake.
- Supports pipeline flush and keeps a saturating taken-branch counter.

---
 rtl/branch_resolve_ctrl_pkg.sv | 8 +
 rtl/ShiftLeft2.sv | 10 +
 rtl/branch_resolve_ctrl.sv | 75 +++++++
 tb/tb_branch_resolve_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// branch_resolve_ctrl_pkg: op and state encodings shared by the branch resolver
package branch_resolve_ctrl_pkg;
  localparam int DEF_DATA_W = 32;
  localparam logic [1:0] OP_BEQ = 2'b00;
  localparam logic [1:0] OP_BNE = 2'b01;
  localparam logic [1:0] OP_J   = 2'b10;
  typedef enum logic [1:0] {IDLE, SHIFT, CALC, DONE} state_t;
endpackage

// File: rtl/ShiftLeft2.sv
// ShiftLeft2: registered shift-left-by-2 unit, one cycle of latency
module ShiftLeft2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= {d[W-3:0], 2'b00};
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: sequences one branch/jump through shift, add and compare to a redirect result
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_pc4,
  input  logic [DATA_W-1:0] req_imm,
  input  logic [DATA_W-1:0] req_rs,
  input  logic [DATA_W-1:0] req_rt,
  input  logic              flush,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [DATA_W-1:0] res_target,
  output logic              busy,
  output logic [CNT_W-1:0]  taken_count
);
  state_t state, state_nx;
  logic [1:0] op;
  logic [DATA_W-1:0] pc4, imm, rs, rt, sh, target_nx;
  logic taken_nx, accept, deliver;
  ShiftLeft2 #(.W(DATA_W)) u_shl (.clk(clk), .d(imm), .q(sh));
  assign req_ready = (state == IDLE) & ~flush & ~reset;
  assign res_valid = state == DONE;
  assign busy      = state != IDLE;
  assign accept    = req_valid & req_ready;
  assign deliver   = res_valid & res_ready & ~flush;
  always_comb begin
    state_nx = flush & busy     ? IDLE :
               state == IDLE    ? (accept ? SHIFT : IDLE) :
               state == SHIFT   ? CALC :
               state == CALC    ? DONE :
               res_ready        ? IDLE : DONE;
  end
  // jump keeps the pc4 region bits; the shifter supplies index<<2 below them
  always_comb begin
    taken_nx  = op == OP_BEQ ? rs == rt : op == OP_BNE ? rs != rt : op == OP_J;
    target_nx = op == OP_J ? {pc4[DATA_W-1 -: 4], sh[DATA_W-5:0]} :
                (op == OP_BEQ || op == OP_BNE) ? pc4 + sh : pc4;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op          <= '0;
      pc4         <= '0;
      imm         <= '0;
      rs          <= '0;
      rt          <= '0;
      res_taken   <= 1'b0;
      res_target  <= '0;
      taken_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op  <= req_op;
        pc4 <= req_pc4;
        imm <= req_imm;
        rs  <= req_rs;
        rt  <= req_rt;
      end
      if (state == CALC && !flush) begin
        res_taken  <= taken_nx;
        res_target <= target_nx;
      end
      if (deliver && res_taken && !(&taken_count)) taken_count <= taken_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed and random stimulus checked against a transaction-level model
module tb_branch_resolve_ctrl;
  localparam int DW = 32;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset, req_valid, req_ready, flush, res_valid, res_ready, res_taken, busy;
  logic [1:0] req_op;
  logic [DW-1:0] req_pc4, req_imm, req_rs, req_rt, res_target;
  logic [CW-1:0] taken_count;
  int checks = 0, failures = 0;
  bit pend, m_taken;
  int age, m_cnt;
  logic [DW-1:0] m_target;
  always #5 clk = ~clk;
  branch_resolve_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_pc4(req_pc4), .req_imm(req_imm), .req_rs(req_rs), .req_rt(req_rt), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken), .res_target(res_target),
    .busy(busy), .taken_count(taken_count)
  );
  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic void resolve(input logic [1:0] op, input logic [DW-1:0] pc4, imm, rs, rt,
                                  output bit tk, output logic [DW-1:0] tg);
    case (op)
      2'd0: begin tk = rs == rt; tg = pc4 + imm * 4; end
      2'd1: begin tk = rs != rt; tg = pc4 + imm * 4; end
      2'd2: begin tk = 1; tg = (pc4 & 32'hF000_0000) | ((imm * 4) & 32'h0FFF_FFFF); end
      default: begin tk = 0; tg = pc4; end
    endcase
  endfunction
  task automatic model_edge();
    if (reset) begin
      pend = 0;
      m_cnt = 0;
    end else if (pend && flush) pend = 0;
    else if (pend && age >= 2 && res_ready) begin
      if (m_taken && m_cnt < (1 << CW) - 1) m_cnt++;
      pend = 0;
    end else if (pend) age++;
    else if (req_valid && !flush) begin
      pend = 1;
      age = 0;
      resolve(req_op, req_pc4, req_imm, req_rs, req_rt, m_taken, m_target);
    end
  endtask
  task automatic compare();
    check("req_ready", req_ready, !pend && !flush && !reset);
    check("busy", busy, pend);
    check("res_valid", res_valid, pend && age >= 2);
    check("taken_count", taken_count, m_cnt);
    if (pend && age >= 2) begin
      check("res_taken", res_taken, m_taken);
      check("res_target", res_target, m_target);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1 compare();
  endtask
  task automatic send(logic [1:0] op, logic [DW-1:0] pc4, imm, rs, rt);
    req_op = op; req_pc4 = pc4; req_imm = imm; req_rs = rs; req_rt = rt;
    req_valid = 1;
    step();
    req_valid = 0;
  endtask
  initial begin
    reset = 0; req_valid = 0; flush = 0; res_ready = 0;
    req_op = 0; req_pc4 = 0; req_imm = 0; req_rs = 0; req_rt = 0;
    pend = 0; age = 0; m_cnt = 0; m_taken = 0; m_target = 0;
    #1 reset = 1;
    #1 compare();
    check("rst_req_ready", req_ready, 0);
    step(); step();
    reset = 0;
    #1 compare();
    send(2'b00, 32'h0040_0004, 32'h0000_0003, 5, 5);
    step(); step();
    check("beq_taken", res_taken, 1);
    check("beq_target", res_target, 32'h0040_0010);
    step(); step(); step();
    check("bp_valid", res_valid, 1);
    check("bp_busy", busy, 1);
    check("bp_req_ready", req_ready, 0);
    res_ready = 1;
    step();
    res_ready = 0;
    check("beq_count", taken_count, 1);
    check("idle_req_ready", req_ready, 1);
    send(2'b01, 32'h0000_0100, 32'hFFFF_FFFE, 1, 2);
    step(); step();
    check("bne_taken", res_taken, 1);
    check("bne_target", res_target, 32'h0000_00F8);
    res_ready = 1; step(); res_ready = 0;
    send(2'b01, 32'h0000_0100, 32'hFFFF_FFFE, 7, 7);
    step(); step();
    check("bne_nt_taken", res_taken, 0);
    check("bne_nt_target", res_target, 32'h0000_00F8);
    res_ready = 1; step(); res_ready = 0;
    check("bne_nt_count", taken_count, 2);
    send(2'b10, 32'hA000_0000, 32'h0000_0040, 0, 0);
    step(); step();
    check("j_taken", res_taken, 1);
    check("j_target", res_target, 32'hA000_0100);
    res_ready = 1; step(); res_ready = 0;
    send(2'b00, 32'h10, 32'h1, 3, 3);
    flush = 1; step(); flush = 0;
    res_ready = 1; step(); step(); step(); res_ready = 0;
    check("flush_shift_count", taken_count, 3);
    send(2'b00, 32'h10, 32'h1, 3, 3);
    step(); step();
    flush = 1; res_ready = 1; step(); flush = 0; res_ready = 0;
    check("flush_done_valid", res_valid, 0);
    check("flush_done_count", taken_count, 3);
    flush = 1; req_valid = 1; step(); flush = 0; req_valid = 0;
    check("flush_idle_busy", busy, 0);
    send(2'b00, 32'h20, 32'h2, 4, 4);
    step();
    #2 reset = 1;
    #1 pend = 0; m_cnt = 0;
    compare();
    check("rst_mid_valid", res_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_count", taken_count, 0);
    step();
    reset = 0;
    send(2'b10, 32'h3000_0000, 32'h0000_0005, 0, 0);
    step(); step();
    check("post_rst_valid", res_valid, 1);
    check("post_rst_target", res_target, 32'h3000_0014);
    res_ready = 1; step(); res_ready = 0;
    for (int i = 0; i < 3000; i++) begin
      req_valid = $urandom_range(0, 1);
      req_op = 2'($urandom_range(0, 3));
      req_pc4 = $urandom;
      req_imm = $urandom;
      req_rs = $urandom_range(0, 3);
      req_rt = $urandom_range(0, 3);
      flush = $urandom_range(0, 11) == 0;
      res_ready = $urandom_range(0, 2) != 0;
      step();
    end
    check("sat_count", taken_count, 4'hF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
